// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped timer/compare peripheral on the CPU data bus.
// Provides a prescaled up-counter with compare match, optional auto-reload,
// sticky write-1-to-clear MATCH/OVF flags and an interrupt request.
module mmio_timer #(
   parameter int DATA_LENGTH     = 32,
   parameter int COUNT_LENGTH    = 32,
   parameter int PRESCALE_LENGTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DATA_LENGTH-1:0] Address,
   input  logic [DATA_LENGTH-1:0] DataIn,
   output logic [DATA_LENGTH-1:0] DataOut,
   input  logic                   Select,
   input  logic                   Write,
   output logic                   Irq
);

   localparam logic [2:0] OFF_CTRL     = 3'd0;
   localparam logic [2:0] OFF_STATUS   = 3'd1;
   localparam logic [2:0] OFF_PRESCALE = 3'd2;
   localparam logic [2:0] OFF_COMPARE  = 3'd3;
   localparam logic [2:0] OFF_COUNT    = 3'd4;

   localparam logic [COUNT_LENGTH-1:0] COUNT_MAX = {COUNT_LENGTH{1'b1}};

   logic [2:0]                 offset;
   logic                       bus_write;
   logic                       wr_ctrl;
   logic                       wr_status;
   logic                       wr_prescale;
   logic                       wr_compare;
   logic                       wr_count;

   logic                       ctrl_en;
   logic                       ctrl_auto_reload;
   logic                       ctrl_ie;
   logic                       status_match;
   logic                       status_ovf;
   logic [PRESCALE_LENGTH-1:0] prescale;
   logic [COUNT_LENGTH-1:0]    compare;
   logic [COUNT_LENGTH-1:0]    count;
   logic [PRESCALE_LENGTH-1:0] pre_cnt;
   logic                       tick;

   // Only the word offset within the block matters; the decoder already
   // qualified the upper address bits through Select.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{Address[DATA_LENGTH-1:5], Address[1:0]};

   assign offset      = Address[4:2];
   assign bus_write   = Select & Write;
   assign wr_ctrl     = bus_write && (offset == OFF_CTRL);
   assign wr_status   = bus_write && (offset == OFF_STATUS);
   assign wr_prescale = bus_write && (offset == OFF_PRESCALE);
   assign wr_compare  = bus_write && (offset == OFF_COMPARE);
   assign wr_count    = bus_write && (offset == OFF_COUNT);

   assign tick = ctrl_en && (pre_cnt == prescale);

   // Configuration registers written directly by the CPU.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ctrl_en          <= 1'b0;
         ctrl_auto_reload <= 1'b0;
         ctrl_ie          <= 1'b0;
         prescale         <= '0;
         compare          <= '0;
      end else begin
         if (wr_ctrl) begin
            ctrl_en          <= DataIn[0];
            ctrl_auto_reload <= DataIn[1];
            ctrl_ie          <= DataIn[2];
         end
         if (wr_prescale) begin
            prescale <= DataIn[PRESCALE_LENGTH-1:0];
         end
         if (wr_compare) begin
            compare <= DataIn[COUNT_LENGTH-1:0];
         end
      end
   end

   // Prescaler: restarts from zero on each tick, on a PRESCALE rewrite and
   // whenever the timer is disabled, so enabling always begins a full interval.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pre_cnt <= '0;
      end else if (!ctrl_en || wr_prescale || tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

   // Main counter and sticky flags; a CPU write to COUNT overrides the tick,
   // and hardware flag sets are placed after W1C clears so the set wins.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count        <= '0;
         status_match <= 1'b0;
         status_ovf   <= 1'b0;
      end else begin
         if (wr_status) begin
            if (DataIn[0]) begin
               status_match <= 1'b0;
            end
            if (DataIn[1]) begin
               status_ovf <= 1'b0;
            end
         end
         if (wr_count) begin
            count <= DataIn[COUNT_LENGTH-1:0];
         end else if (tick) begin
            if (count == compare) begin
               status_match <= 1'b1;
            end
            if ((count == compare) && ctrl_auto_reload) begin
               count <= '0;
            end else begin
               count <= count + 1'b1;
               if (count == COUNT_MAX) begin
                  status_ovf <= 1'b1;
               end
            end
         end
      end
   end

   // Zero-latency read mux; a deselected bus or a reserved offset reads zero.
   always_comb begin
      DataOut = '0;
      if (Select) begin
         case (offset)
            OFF_CTRL: begin
               DataOut[2:0] = {ctrl_ie, ctrl_auto_reload, ctrl_en};
            end
            OFF_STATUS: begin
               DataOut[1:0] = {status_ovf, status_match};
            end
            OFF_PRESCALE: begin
               DataOut[PRESCALE_LENGTH-1:0] = prescale;
            end
            OFF_COMPARE: begin
               DataOut[COUNT_LENGTH-1:0] = compare;
            end
            OFF_COUNT: begin
               DataOut[COUNT_LENGTH-1:0] = count;
            end
            default: begin
               DataOut = '0;
            end
         endcase
      end
   end

   assign Irq = status_match & ctrl_ie;

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed self-checking bench for the mmio_timer peripheral.
module tb_mmio_timer;

   localparam logic [31:0] A_CTRL     = 32'h00;
   localparam logic [31:0] A_STATUS   = 32'h04;
   localparam logic [31:0] A_PRESCALE = 32'h08;
   localparam logic [31:0] A_COMPARE  = 32'h0C;
   localparam logic [31:0] A_COUNT    = 32'h10;
   localparam logic [31:0] A_RESERVED = 32'h14;

   logic        clk;
   logic        rst;
   logic [31:0] Address;
   logic [31:0] DataIn;
   logic [31:0] DataOut;
   logic        Select;
   logic        Write;
   logic        Irq;

   int          checks;
   int          errors;
   logic [31:0] rdata;

   mmio_timer #(
      .DATA_LENGTH(32),
      .COUNT_LENGTH(32),
      .PRESCALE_LENGTH(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .Address(Address),
      .DataIn(DataIn),
      .DataOut(DataOut),
      .Select(Select),
      .Write(Write),
      .Irq(Irq)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One bus write spanning exactly one rising edge; returns 1 unit after it.
   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
      Address = addr;
      DataIn  = data;
      Select  = 1'b1;
      Write   = 1'b1;
      @(posedge clk);
      #1;
      Select  = 1'b0;
      Write   = 1'b0;
      Address = '0;
      DataIn  = '0;
   endtask

   // Combinational read; consumes no clock edge.
   task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
      Address = addr;
      Select  = 1'b1;
      Write   = 1'b0;
      #1;
      data    = DataOut;
      Select  = 1'b0;
      Address = '0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] addrs [5];
      addrs = '{A_CTRL, A_STATUS, A_PRESCALE, A_COMPARE, A_COUNT};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         bus_read(addrs[i], rdata);
         checks++;
         if (rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_reg@%h: got %h expected %h", addrs[i], rdata, 32'h0);
         end
      end
      checks++;
      if (Irq !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_irq: got %b expected %b", Irq, 1'b0);
      end
      bus_write(A_RESERVED, 32'hDEAD_BEEF);
      bus_read(A_RESERVED, rdata);
      checks++;
      if (rdata !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reserved_read: got %h expected %h", rdata, 32'h0);
      end
      bus_write(A_PRESCALE, 32'hABCD_1234);
      bus_read(A_PRESCALE, rdata);
      checks++;
      if (rdata !== 32'h0000_1234) begin
         errors++;
         $display("[TB] FAIL prescale_width: got %h expected %h", rdata, 32'h0000_1234);
      end
      bus_write(A_CTRL, 32'hFFFF_FFF8);
      bus_read(A_CTRL, rdata);
      checks++;
      if (rdata !== 32'h0) begin
         errors++;
         $display("[TB] FAIL ctrl_upper_bits: got %h expected %h", rdata, 32'h0);
      end
      Address = A_COMPARE;
      DataIn  = 32'h5;
      Select  = 1'b0;
      Write   = 1'b1;
      #1;
      checks++;
      if (DataOut !== 32'h0) begin
         errors++;
         $display("[TB] FAIL deselected_read: got %h expected %h", DataOut, 32'h0);
      end
      @(posedge clk);
      #1;
      Write = 1'b0;
      bus_read(A_COMPARE, rdata);
      checks++;
      if (rdata !== 32'h0) begin
         errors++;
         $display("[TB] FAIL write_without_select: got %h expected %h", rdata, 32'h0);
      end
   endtask

   task automatic test_auto_reload();
      logic [31:0] exp_seq [4];
      logic [31:0] exp_status;
      exp_seq = '{32'd1, 32'd2, 32'd3, 32'd0};
      do_reset();
      bus_write(A_PRESCALE, 32'd0);
      bus_write(A_COMPARE, 32'd3);
      bus_write(A_CTRL, 32'h3);
      bus_read(A_COUNT, rdata);
      checks++;
      if (rdata !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reload_start_count: got %h expected %h", rdata, 32'd0);
      end
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         bus_read(A_COUNT, rdata);
         checks++;
         if (rdata !== exp_seq[i % 4]) begin
            errors++;
            $display("[TB] FAIL reload_count[%0d]: got %h expected %h", i, rdata, exp_seq[i % 4]);
         end
         exp_status = (i >= 3) ? 32'h1 : 32'h0;
         bus_read(A_STATUS, rdata);
         checks++;
         if (rdata !== exp_status) begin
            errors++;
            $display("[TB] FAIL reload_status[%0d]: got %h expected %h", i, rdata, exp_status);
         end
      end
   endtask

   task automatic test_irq();
      do_reset();
      bus_write(A_PRESCALE, 32'd4);
      bus_write(A_COMPARE, 32'd1);
      bus_write(A_CTRL, 32'h7);
      repeat (9) @(posedge clk);
      #1;
      checks++;
      if (Irq !== 1'b0) begin
         errors++;
         $display("[TB] FAIL irq_before_match: got %b expected %b", Irq, 1'b0);
      end
      @(posedge clk);
      #1;
      checks++;
      if (Irq !== 1'b1) begin
         errors++;
         $display("[TB] FAIL irq_first_match: got %b expected %b", Irq, 1'b1);
      end
      bus_write(A_STATUS, 32'h1);
      checks++;
      if (Irq !== 1'b0) begin
         errors++;
         $display("[TB] FAIL irq_after_w1c: got %b expected %b", Irq, 1'b0);
      end
      repeat (8) @(posedge clk);
      #1;
      checks++;
      if (Irq !== 1'b0) begin
         errors++;
         $display("[TB] FAIL irq_before_second: got %b expected %b", Irq, 1'b0);
      end
      @(posedge clk);
      #1;
      checks++;
      if (Irq !== 1'b1) begin
         errors++;
         $display("[TB] FAIL irq_second_match: got %b expected %b", Irq, 1'b1);
      end
      bus_write(A_CTRL, 32'h3);
      checks++;
      if (Irq !== 1'b0) begin
         errors++;
         $display("[TB] FAIL irq_gated_by_ie: got %b expected %b", Irq, 1'b0);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      bus_write(A_PRESCALE, 32'd0);
      bus_write(A_COMPARE, 32'd5);
      bus_write(A_COUNT, 32'hFFFF_FFFE);
      bus_write(A_CTRL, 32'h1);
      @(posedge clk);
      #1;
      bus_read(A_COUNT, rdata);
      checks++;
      if (rdata !== 32'hFFFF_FFFF) begin
         errors++;
         $display("[TB] FAIL ovf_count_max: got %h expected %h", rdata, 32'hFFFF_FFFF);
      end
      @(posedge clk);
      #1;
      bus_read(A_COUNT, rdata);
      checks++;
      if (rdata !== 32'h0) begin
         errors++;
         $display("[TB] FAIL ovf_count_wrap: got %h expected %h", rdata, 32'h0);
      end
      bus_read(A_STATUS, rdata);
      checks++;
      if (rdata !== 32'h2) begin
         errors++;
         $display("[TB] FAIL ovf_status: got %h expected %h", rdata, 32'h2);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      bus_write(A_PRESCALE, 32'd0);
      bus_write(A_COMPARE, 32'd3);
      bus_write(A_CTRL, 32'h3);
      repeat (7) @(posedge clk);
      #1;
      bus_read(A_COUNT, rdata);
      checks++;
      if (rdata !== 32'd3) begin
         errors++;
         $display("[TB] FAIL b2b_count_pre: got %h expected %h", rdata, 32'd3);
      end
      bus_write(A_STATUS, 32'h1);
      bus_read(A_STATUS, rdata);
      checks++;
      if (rdata !== 32'h1) begin
         errors++;
         $display("[TB] FAIL b2b_set_wins: got %h expected %h", rdata, 32'h1);
      end
      bus_write(A_STATUS, 32'h1);
      bus_read(A_STATUS, rdata);
      checks++;
      if (rdata !== 32'h0) begin
         errors++;
         $display("[TB] FAIL b2b_w1c_clear: got %h expected %h", rdata, 32'h0);
      end
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      bus_read(A_COUNT, rdata);
      checks++;
      if (rdata !== 32'd3) begin
         errors++;
         $display("[TB] FAIL b2b_count_at_cmp: got %h expected %h", rdata, 32'd3);
      end
      bus_write(A_COUNT, 32'd7);
      bus_read(A_COUNT, rdata);
      checks++;
      if (rdata !== 32'd7) begin
         errors++;
         $display("[TB] FAIL b2b_count_write_wins: got %h expected %h", rdata, 32'd7);
      end
      bus_read(A_STATUS, rdata);
      checks++;
      if (rdata !== 32'h0) begin
         errors++;
         $display("[TB] FAIL b2b_no_match_on_write: got %h expected %h", rdata, 32'h0);
      end
      bus_write(A_CTRL, 32'h0);
   endtask

   task automatic test_reset_mid_count();
      do_reset();
      bus_write(A_PRESCALE, 32'd0);
      bus_write(A_COMPARE, 32'h10);
      bus_write(A_CTRL, 32'h5);
      repeat (32) @(posedge clk);
      #1;
      bus_read(A_COUNT, rdata);
      checks++;
      if (rdata !== 32'h20) begin
         errors++;
         $display("[TB] FAIL midrst_count_pre: got %h expected %h", rdata, 32'h20);
      end
      checks++;
      if (Irq !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midrst_irq_pre: got %b expected %b", Irq, 1'b1);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus_read(A_COUNT, rdata);
      checks++;
      if (rdata !== 32'h0) begin
         errors++;
         $display("[TB] FAIL midrst_count: got %h expected %h", rdata, 32'h0);
      end
      bus_read(A_CTRL, rdata);
      checks++;
      if (rdata !== 32'h0) begin
         errors++;
         $display("[TB] FAIL midrst_ctrl: got %h expected %h", rdata, 32'h0);
      end
      checks++;
      if (Irq !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midrst_irq: got %b expected %b", Irq, 1'b0);
      end
      repeat (5) @(posedge clk);
      #1;
      bus_read(A_COUNT, rdata);
      checks++;
      if (rdata !== 32'h0) begin
         errors++;
         $display("[TB] FAIL midrst_stopped: got %h expected %h", rdata, 32'h0);
      end
      bus_write(A_CTRL, 32'h1);
      repeat (3) @(posedge clk);
      #1;
      bus_read(A_COUNT, rdata);
      checks++;
      if (rdata !== 32'd3) begin
         errors++;
         $display("[TB] FAIL midrst_restart: got %h expected %h", rdata, 32'd3);
      end
   endtask

   // Scenario sequence; each scenario starts from its own reset.
   initial begin
      checks  = 0;
      errors  = 0;
      rst     = 1'b0;
      Address = '0;
      DataIn  = '0;
      Select  = 1'b0;
      Write   = 1'b0;
      test_reset();
      test_auto_reload();
      test_irq();
      test_overflow();
      test_back_to_back();
      test_reset_mid_count();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
